// File: rtl/div_frec_pkg.sv
// Shared constants, default half-period table and table lookup helper for
// the multi-channel frequency divider.
package div_frec_pkg;

    localparam int CNT_W_DFLT = 26;
    localparam int TBL_N      = 16;
    localparam int TBL_W_MAX  = 32;

    // Half-period limits for a 100 MHz clk: output period = 2*(L+1) cycles.
    // Entry 0 (LSBs) = 10 us, entry 1 = 20 us, entries 2..15 = 50 ms..700 ms in 50 ms steps.
    localparam logic [TBL_N*CNT_W_DFLT-1:0] DFLT = {
        26'd34999999, 26'd32499999, 26'd29999999, 26'd27499999,
        26'd24999999, 26'd22499999, 26'd19999999, 26'd17499999,
        26'd14999999, 26'd12499999, 26'd9999999,  26'd7499999,
        26'd4999999,  26'd2499999,  26'd999,      26'd499
    };

    // Pick entry idx out of a table whose entries are widened to TBL_W_MAX bits.
    function automatic logic [TBL_W_MAX-1:0] tbl_get(
        input logic [TBL_N*TBL_W_MAX-1:0] tbl,
        input logic [3:0]                 idx
    );
        return tbl[32'(idx)*TBL_W_MAX +: TBL_W_MAX];
    endfunction

endpackage

// File: rtl/div_frec_chan.sv
// One divider channel: half-period counter, latched limit, square output
// and a one-cycle tick on every rising edge of the output.
//
// Mode     | meaning
// ---------|-----------------------------------------------------------
// hold     | restart=1 or en=0: cnt/clk_out/tick cleared, lim follows sel
// count    | cnt != lim: cnt increments, tick low
// wrap     | cnt == lim: cnt cleared, clk_out flips, lim reloaded from sel
module div_frec_chan
    import div_frec_pkg::*;
#(
    parameter int                     CNT_W        = CNT_W_DFLT,
    parameter logic [TBL_N*CNT_W-1:0] PERIOD_TABLE = DFLT,
    parameter int                     DEFAULT_SEL  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       restart,
    input  logic [3:0] sel,
    output logic       clk_out,
    output logic       tick
);

    localparam logic [CNT_W-1:0] LIM_RST = PERIOD_TABLE[DEFAULT_SEL*CNT_W +: CNT_W];

    logic [TBL_N*TBL_W_MAX-1:0] tbl_wide;
    logic [CNT_W-1:0]           lim_sel;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    for (genvar k = 0; k < TBL_N; k++) begin : g_tbl
        assign tbl_wide[k*TBL_W_MAX +: TBL_W_MAX] = TBL_W_MAX'(PERIOD_TABLE[k*CNT_W +: CNT_W]);
    end

    assign lim_sel = CNT_W'(tbl_get(tbl_wide, sel));

    // Next-state: restart beats disable beats counting; lim only reloads at cnt==0 points.
    always_comb begin
        cnt_d     = cnt_q;
        lim_d     = lim_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (restart || !en) begin
            cnt_d     = '0;
            lim_d     = lim_sel;
            clk_out_d = 1'b0;
        end else if (cnt_q == lim_q) begin
            cnt_d     = '0;
            lim_d     = lim_sel;
            clk_out_d = ~clk_out_q;
            tick_d    = ~clk_out_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            lim_q     <= LIM_RST;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lim_q     <= lim_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/div_frec_multi.sv
// Multi-channel adjustable frequency divider: slices en/sel per channel
// and fans restart out to every channel instance.
module div_frec_multi
    import div_frec_pkg::*;
#(
    parameter int                     NUM_CH       = 4,
    parameter int                     CNT_W        = CNT_W_DFLT,
    parameter logic [TBL_N*CNT_W-1:0] PERIOD_TABLE = DFLT,
    parameter int                     DEFAULT_SEL  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     en,
    input  logic                  restart,
    input  logic [4*NUM_CH-1:0]   sel,
    output logic [NUM_CH-1:0]     clk_out,
    output logic [NUM_CH-1:0]     tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        div_frec_chan #(
            .CNT_W        (CNT_W),
            .PERIOD_TABLE (PERIOD_TABLE),
            .DEFAULT_SEL  (DEFAULT_SEL)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .restart (restart),
            .sel     (sel[4*i +: 4]),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_div_frec_multi.sv
// Scoreboard bench for div_frec_multi with a small table (entry k = k).
module tb_div_frec_multi;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    function automatic logic [16*CNT_W-1:0] mk_tbl();
        logic [16*CNT_W-1:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) t[k*CNT_W +: CNT_W] = CNT_W'(k);
        return t;
    endfunction

    localparam logic [16*CNT_W-1:0] TB_TBL = mk_tbl();

    logic                clk     = 1'b0;
    logic                clk_run = 1'b1;
    logic                rst     = 1'b0;
    logic                restart = 1'b0;
    logic [NUM_CH-1:0]   en      = '0;
    logic [4*NUM_CH-1:0] sel     = '0;
    logic [NUM_CH-1:0]   clk_out;
    logic [NUM_CH-1:0]   tick;

    typedef struct {
        string      nm;
        logic [1:0] co;
        logic [1:0] tk;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    div_frec_multi #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .PERIOD_TABLE (TB_TBL),
        .DEFAULT_SEL  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (restart),
        .sel     (sel),
        .clk_out (clk_out),
        .tick    (tick)
    );

    // Gateable clock so reset can be exercised with the clock stopped.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Monitor: every checked edge has exactly one expectation queued before it.
    always begin
        @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_chk++;
            if (clk_out !== mon_e.co || tick !== mon_e.tk) begin
                n_fail++;
                $display("FAIL %s: clk_out=%b tick=%b, expected clk_out=%b tick=%b at %0t",
                         mon_e.nm, clk_out, tick, mon_e.co, mon_e.tk, $time);
            end
        end
    end

    // Expected square wave n edges after counting starts from cnt=0, half-period L+1.
    function automatic logic w_co(int l, int n);
        return ((n / (l + 1)) % 2) == 1;
    endfunction

    function automatic logic w_tk(int l, int n);
        return ((n % (l + 1)) == 0) && (((n / (l + 1)) % 2) == 1);
    endfunction

    task automatic cyc(input string nm, input logic [1:0] co, input logic [1:0] tk);
        exp_t e;
        e.nm = nm;
        e.co = co;
        e.tk = tk;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Channel 0 vector from '0'/'1' strings; channel 1 expected idle.
    task automatic run_str(input string nm, input string co0, input string tk0);
        for (int i = 0; i < co0.len(); i++)
            cyc(nm, {1'b0, co0[i] == "1"}, {1'b0, tk0[i] == "1"});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // Reset held with clock running, then released with channels disabled.
        for (int i = 0; i < 4; i++) cyc("rst_hold", 2'b00, 2'b00);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) cyc("rst_rel", 2'b00, 2'b00);

        // L=0: divide-by-2, tick on every rising edge.
        sel = 8'h00;
        en  = 2'b00;
        cyc("t2_dis", 2'b00, 2'b00);
        en = 2'b01;
        for (int n = 1; n <= 13; n++)
            cyc("t2_div2", {1'b0, w_co(0, n)}, {1'b0, w_tk(0, n)});

        // Asynchronous reset with the clock stopped while clk_out[0] and tick[0] are high.
        chk("pre_rst_clk_out0", 32'(clk_out[0]), 32'd1);
        chk("pre_rst_tick0", 32'(tick[0]), 32'd1);
        clk_run = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_clk_out", 32'(clk_out), 32'd0);
        chk("async_rst_tick", 32'(tick), 32'd0);
        #5;
        rst     = 1'b1;
        en      = 2'b00;
        clk_run = 1'b1;
        @(negedge clk);

        // L=3: 4 high / 4 low over 10 full periods.
        sel = 8'h03;
        cyc("t3_dis", 2'b00, 2'b00);
        cyc("t3_dis", 2'b00, 2'b00);
        en = 2'b01;
        for (int n = 1; n <= 80; n++)
            cyc("t3_div8", {1'b0, w_co(3, n)}, {1'b0, w_tk(3, n)});

        // sel 3 -> 1 when cnt=1: current half stays 4 cycles, then 2-cycle halves.
        en  = 2'b00;
        sel = 8'h03;
        cyc("t4_dis", 2'b00, 2'b00);
        cyc("t4_dis", 2'b00, 2'b00);
        en = 2'b01;
        run_str("t4_sel_chg", "00011", "00010");
        sel = 8'h01;
        run_str("t4_sel_chg", "11001100110", "00001000100");

        // Gate while high forces low next edge; re-enable rises after exactly 4 cycles.
        en  = 2'b00;
        sel = 8'h03;
        cyc("t5_dis", 2'b00, 2'b00);
        cyc("t5_dis", 2'b00, 2'b00);
        en = 2'b01;
        run_str("t5_run", "00011", "00010");
        en = 2'b00;
        run_str("t5_gate", "000", "000");
        en = 2'b01;
        run_str("t5_reen", "00011110", "00010000");

        // Two channels at L=2 out of phase, realigned by a one-cycle restart.
        en  = 2'b00;
        sel = 8'h22;
        cyc("t6_dis", 2'b00, 2'b00);
        cyc("t6_dis", 2'b00, 2'b00);
        en = 2'b01;
        for (int n = 1; n <= 2; n++)
            cyc("t6_ch0_lead", {1'b0, w_co(2, n)}, {1'b0, w_tk(2, n)});
        en = 2'b11;
        for (int i = 0; i < 4; i++)
            cyc("t6_skew", {w_co(2, i + 1), w_co(2, i + 3)}, {w_tk(2, i + 1), w_tk(2, i + 3)});
        restart = 1'b1;
        cyc("t6_restart", 2'b00, 2'b00);
        restart = 1'b0;
        for (int n = 1; n <= 12; n++)
            cyc("t6_aligned", {w_co(2, n), w_co(2, n)}, {w_tk(2, n), w_tk(2, n)});

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
